// File: rtl/beat_monitor.sv
// beat_monitor: measures half-periods of an asynchronous square wave and flags liveness / frequency tolerance.
// Optional feature macro: BEAT_MONITOR_EDGE_COUNT_EN enables the wrapping 16-bit edge counter.
module beat_monitor #(
    parameter int unsigned CLK_FREQ  = 32'd50000000,
    parameter int unsigned BEAT_FREQ = 32'd5,
    parameter int unsigned TOL_PCT   = 32'd25
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        beat_in,
    output logic [31:0] half_period,
    output logic        period_valid,
    output logic        alive,
    output logic        freq_ok,
    output logic        lost,
    output logic [15:0] edge_count
);

    localparam logic [31:0] EXP_C  = 32'(CLK_FREQ / 32'd2 / BEAT_FREQ);
    localparam logic [31:0] DEV_C  = 32'(EXP_C * TOL_PCT / 32'd100);
    localparam logic [31:0] LO_C   = EXP_C - DEV_C;
    localparam logic [31:0] HI_C   = EXP_C + DEV_C;
    localparam logic [31:0] TMO_C  = 32'd2 * HI_C;
    localparam logic [31:0] LAST_C = TMO_C - 32'd1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_TRACK = 2'd2
    } state_t;

    state_t      state_r;
    logic        s1_r;
    logic        s2_r;
    logic        s3_r;
    logic [31:0] cnt_r;
    logic [31:0] half_period_r;
    logic        period_valid_r;
    logic        alive_r;
    logic        freq_ok_r;
    logic        lost_r;

    logic        edge_s;
    logic        timeout_s;
    logic [31:0] meas_s;
    logic        in_tol_s;

    // Edge detect, candidate measurement and timeout qualification (edge beats timeout)
    always_comb begin
        edge_s    = s2_r ^ s3_r;
        meas_s    = cnt_r + 32'd1;
        in_tol_s  = (meas_s >= LO_C) && (meas_s <= HI_C);
        timeout_s = (cnt_r == LAST_C) && !edge_s;
    end

    // Two-flop synchronizer followed by the history flop used for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_r <= 1'b0;
            s2_r <= 1'b0;
            s3_r <= 1'b0;
        end else begin
            s1_r <= beat_in;
            s2_r <= s1_r;
            s3_r <= s2_r;
        end
    end

    // Interval counter: cleared by an edge, saturates one below the timeout length
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= 32'd0;
        end else if (edge_s) begin
            cnt_r <= 32'd0;
        end else if (cnt_r != LAST_C) begin
            cnt_r <= cnt_r + 32'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Monitor FSM with registered status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= ST_IDLE;
            half_period_r  <= 32'd0;
            period_valid_r <= 1'b0;
            alive_r        <= 1'b0;
            freq_ok_r      <= 1'b0;
            lost_r         <= 1'b0;
        end else begin
            period_valid_r <= 1'b0;
            lost_r         <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (edge_s) begin
                        state_r <= ST_ARMED;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ARMED, ST_TRACK: begin
                    if (edge_s) begin
                        half_period_r  <= meas_s;
                        period_valid_r <= 1'b1;
                        alive_r        <= 1'b1;
                        freq_ok_r      <= in_tol_s;
                        state_r        <= ST_TRACK;
                    end else if (timeout_s) begin
                        // Only a tracked beat can be reported as lost
                        lost_r        <= (state_r == ST_TRACK);
                        alive_r       <= 1'b0;
                        freq_ok_r     <= 1'b0;
                        half_period_r <= 32'd0;
                        state_r       <= ST_IDLE;
                    end else begin
                        state_r <= state_r;
                    end
                end
                default: begin
                    state_r       <= ST_IDLE;
                    alive_r       <= 1'b0;
                    freq_ok_r     <= 1'b0;
                    half_period_r <= 32'd0;
                end
            endcase
        end
    end

    assign half_period  = half_period_r;
    assign period_valid = period_valid_r;
    assign alive        = alive_r;
    assign freq_ok      = freq_ok_r;
    assign lost         = lost_r;

`ifdef BEAT_MONITOR_EDGE_COUNT_EN
    logic [15:0] edge_count_r;

    // Wrapping count of every detected edge, arming edges included
    always_ff @(posedge clk) begin
        if (rst) begin
            edge_count_r <= 16'd0;
        end else if (edge_s) begin
            edge_count_r <= edge_count_r + 16'd1;
        end else begin
            edge_count_r <= edge_count_r;
        end
    end

    assign edge_count = edge_count_r;
`else
    assign edge_count = 16'd0;
`endif

endmodule
